// File: rtl/sfp_accum_array.sv
// sfp_accum_array
// Multi-pass special function processor between the OFIFO and the output
// SRAM. Psum vectors from several K-tile passes are accumulated into an
// internal row buffer with signed saturation. The buffer is then drained
// through a registered output stage. The drain stage can apply ReLU and
// tracks the per-lane maximum and the row that produced it.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 job start pulse (only honoured while idle)
//   cfg_rows/passes/relu  job configuration, captured on start
//   in_valid/in_ready     input vector handshake (ready only while accumulating)
//   in_data               col lanes of psum_bw bits, lane i at [psum_bw*i +: psum_bw]
//   out_valid/out_ready   output vector handshake
//   out_data/out_row      drained (post-ReLU) row and its row index
//   max_val/max_idx       per-lane running maximum and the row index of it
//   busy/done             busy while a job runs; done pulses for one cycle at job end
module sfp_accum_array #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int AW      = $clog2(depth) + 1,
  parameter int PW      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW-1:0]          cfg_rows,
  input  logic [PW-1:0]          cfg_passes,
  input  logic                   cfg_relu,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [psum_bw*col-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [psum_bw*col-1:0] out_data,
  output logic [AW-1:0]          out_row,
  output logic [psum_bw*col-1:0] max_val,
  output logic [AW*col-1:0]      max_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = psum_bw * col;
  localparam int IW = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rows_q, rows_d;
  logic [PW-1:0] passes_q, passes_d;
  logic          relu_q, relu_d;
  logic [AW-1:0] row_ptr_q, row_ptr_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_row_q, out_row_d;
  logic [DW-1:0] max_val_q, max_val_d;
  logic [AW*col-1:0] max_idx_q, max_idx_d;

  logic [DW-1:0] buf_mem [depth];
  logic          wr_en;
  logic [DW-1:0] acc_cur, drain_cur, acc_data, relu_data;
  logic [AW-1:0] rows_clamped;
  logic          out_hs;

  // Two's complement add of one lane, clamped on overflow. Overflow shows up
  // as a disagreement between the sign-extension bit and the result sign.
  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) begin
      sat_add = s[psum_bw] ? LANE_MIN : LANE_MAX;
    end else begin
      sat_add = s[psum_bw-1:0];
    end
  endfunction

  assign rows_clamped = (cfg_rows > AW'(depth)) ? AW'(depth) : cfg_rows;
  assign out_hs       = out_valid_q & out_ready;

  // Lane datapaths: accumulation (overwrite on the first pass) and the ReLU
  // applied to the row about to be drained.
  always_comb begin
    acc_cur   = buf_mem[row_ptr_q[IW-1:0]];
    drain_cur = buf_mem[rd_ptr_q[IW-1:0]];
    acc_data  = '0;
    relu_data = '0;
    for (int i = 0; i < col; i++) begin
      if (pass_cnt_q == '0) begin
        acc_data[i*psum_bw +: psum_bw] = in_data[i*psum_bw +: psum_bw];
      end else begin
        acc_data[i*psum_bw +: psum_bw] = sat_add(acc_cur[i*psum_bw +: psum_bw],
                                                 in_data[i*psum_bw +: psum_bw]);
      end
      if (relu_q && drain_cur[i*psum_bw + psum_bw - 1]) begin
        relu_data[i*psum_bw +: psum_bw] = '0;
      end else begin
        relu_data[i*psum_bw +: psum_bw] = drain_cur[i*psum_bw +: psum_bw];
      end
    end
  end

  // Control FSM and next-state of every register.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    passes_d    = passes_q;
    relu_d      = relu_q;
    row_ptr_d   = row_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d     = rows_clamped;
          passes_d   = cfg_passes;
          relu_d     = cfg_relu;
          max_val_d  = {col{LANE_MIN}};
          max_idx_d  = '0;
          row_ptr_d  = '0;
          pass_cnt_d = '0;
          if (rows_clamped == '0 || cfg_passes == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (row_ptr_q == rows_q - 1'b1) begin
            row_ptr_d  = '0;
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (pass_cnt_q == passes_q - 1'b1) begin
              state_d  = S_DRAIN;
              rd_ptr_d = '0;
            end
          end else begin
            row_ptr_d = row_ptr_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        // The max tracker sees exactly the rows accepted downstream; strict
        // compare keeps the earliest row on ties.
        if (out_hs) begin
          for (int i = 0; i < col; i++) begin
            if ($signed(out_data_q[i*psum_bw +: psum_bw]) >
                $signed(max_val_q[i*psum_bw +: psum_bw])) begin
              max_val_d[i*psum_bw +: psum_bw] = out_data_q[i*psum_bw +: psum_bw];
              max_idx_d[i*AW +: AW]           = out_row_q;
            end
          end
        end
        if ((!out_valid_q || out_ready) && (rd_ptr_q < rows_q)) begin
          out_data_d  = relu_data;
          out_row_d   = rd_ptr_q;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = S_FIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      passes_q    <= '0;
      relu_q      <= 1'b0;
      row_ptr_q   <= '0;
      pass_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      passes_q    <= passes_d;
      relu_q      <= relu_d;
      row_ptr_q   <= row_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
    end
  end

  // Row buffer has no reset; a write landing on the reset edge is suppressed
  // so an aborted job cannot leave a half-committed vector behind.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      buf_mem[row_ptr_q[IW-1:0]] <= acc_data;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign max_val   = max_val_q;
  assign max_idx   = max_idx_q;

endmodule

// File: tb/tb_sfp_accum_array.sv
// tb_sfp_accum_array
// Directed bench for sfp_accum_array. Expected rows are computed by a small
// saturating-accumulate model, queued as the last pass of each row is driven
// and popped as the DUT drains. Max tracking is modelled alongside.
module tb_sfp_accum_array;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = 5;
  localparam int PW      = 8;
  localparam int DW      = PSUM_BW * COL;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     cfg_rows;
  logic [PW-1:0]     cfg_passes;
  logic              cfg_relu;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_row;
  logic [DW-1:0]     max_val;
  logic [AW*COL-1:0] max_idx;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] row;
  } expRow_t;

  expRow_t expQ[$];
  int checkCnt = 0;
  int failCnt  = 0;
  int modelAcc [DEPTH][COL];
  int modelMax [COL];
  int modelIdx [COL];

  sfp_accum_array #(
    .psum_bw(PSUM_BW), .col(COL), .depth(DEPTH), .AW(AW), .PW(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_passes(cfg_passes), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .max_val(max_val), .max_idx(max_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and counts and reports it when it fails.
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checkCnt++;
    assert (obs === expv) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Lane value generator for the directed patterns.
  function automatic int genLane(input int mode, input int p, input int r, input int l);
    case (mode)
      0: genLane = r + 1;
      1: genLane = 100;
      2: genLane = 20000;
      3: genLane = (l == 0) ? ((r == 0) ? -5 : (r == 1) ? -7 : -1) : (r * 5 - 3 + l);
      4: genLane = 1000 + 10 * r + l + p;
      default: genLane = 0;
    endcase
  endfunction

  function automatic int satModel(input int v);
    if (v > 32767) satModel = 32767;
    else if (v < -32768) satModel = -32768;
    else satModel = v;
  endfunction

  function automatic logic [DW-1:0] maxValVec();
    logic [DW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*PSUM_BW +: PSUM_BW] = 16'(modelMax[l]);
    return v;
  endfunction

  function automatic logic [DW-1:0] maxIdxVec();
    logic [DW-1:0] v;
    v = '0;
    for (int l = 0; l < COL; l++) v[l*AW +: AW] = AW'(modelIdx[l]);
    return v;
  endfunction

  // Starts a job and feeds every input vector, optionally with idle gaps.
  task automatic applyStimulus(input int rows, input int passes, input int relu,
                               input int mode, input int gaps);
    int effRows;
    logic [DW-1:0] vec;
    logic [DW-1:0] expData;
    effRows = (rows > DEPTH) ? DEPTH : rows;
    for (int l = 0; l < COL; l++) begin
      modelMax[l] = -32768;
      modelIdx[l] = 0;
    end
    cfg_rows   = AW'(rows);
    cfg_passes = PW'(passes);
    cfg_relu   = relu[0];
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (effRows == 0 || passes == 0) begin
      chk("done_empty_job", done, 1);
      chk("in_ready_empty_job", in_ready, 0);
      chk("max_val_loaded", max_val, maxValVec());
      chk("max_idx_loaded", max_idx, maxIdxVec());
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("busy_idle_again", busy, 0);
      chk("out_valid_empty_job", out_valid, 0);
      return;
    end
    for (int p = 0; p < passes; p++) begin
      for (int r = 0; r < effRows; r++) begin
        if (gaps != 0 && ((p * effRows + r) % 3 == 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        chk("in_ready_accum", in_ready, 1);
        for (int l = 0; l < COL; l++) begin
          int v;
          v = genLane(mode, p, r, l);
          vec[l*PSUM_BW +: PSUM_BW] = 16'(v);
          modelAcc[r][l] = (p == 0) ? v : satModel(modelAcc[r][l] + v);
        end
        if (p == passes - 1) begin
          for (int l = 0; l < COL; l++) begin
            int o;
            o = (relu != 0 && modelAcc[r][l] < 0) ? 0 : modelAcc[r][l];
            expData[l*PSUM_BW +: PSUM_BW] = 16'(o);
            if (o > modelMax[l]) begin
              modelMax[l] = o;
              modelIdx[l] = r;
            end
          end
          expQ.push_back('{data: expData, row: AW'(r)});
        end
        in_data  = vec;
        in_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("in_ready_drain_entry", in_ready, 0);
    chk("out_valid_drain_entry", out_valid, 0);
  endtask

  // Drains the job against the queue, with optional back-pressure, then
  // checks the done pulse and the max tracker.
  task automatic checkOutput(input int stall, input bit pokeStart);
    int  cycles;
    bit  lastPopped;
    bit  finished;
    cycles     = 0;
    lastPopped = 1'b0;
    finished   = 1'b0;
    while (!finished && cycles < 400) begin
      chk("done_timing", done, lastPopped);
      if (lastPopped) begin
        finished = 1'b1;
      end else begin
        chk("in_ready_in_drain", in_ready, 0);
        if (out_valid === 1'b1) begin
          if (expQ.size() == 0) begin
            chk("extra_output", out_valid, 0);
          end else begin
            chk("out_data", out_data, expQ[0].data);
            chk("out_row", out_row, expQ[0].row);
          end
        end
        out_ready = (stall != 0) ? (cycles % 3 == 0) : 1'b1;
        start     = pokeStart;
        if (out_valid === 1'b1 && out_ready && expQ.size() > 0) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) lastPopped = 1'b1;
        end
        @(posedge clk); #1;
        cycles++;
      end
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk("drain_finished", finished, 1);
    chk("max_val", max_val, maxValVec());
    chk("max_idx", max_idx, maxIdxVec());
    @(posedge clk); #1;
    chk("done_cleared", done, 0);
    chk("busy_cleared", busy, 0);
    chk("out_valid_cleared", out_valid, 0);
    expQ.delete();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    cfg_rows   = '0;
    cfg_passes = '0;
    cfg_relu   = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_row", out_row, 0);
    chk("reset_max_val", max_val, 0);
    chk("reset_max_idx", max_idx, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single pass passthrough");
    applyStimulus(4, 1, 0, 0, 0);
    checkOutput(0, 0);

    $display("[TB] three-pass accumulation and saturation");
    applyStimulus(2, 3, 0, 1, 0);
    checkOutput(0, 0);
    applyStimulus(2, 3, 0, 2, 1);
    checkOutput(0, 0);

    $display("[TB] relu with tied maxima");
    applyStimulus(3, 1, 1, 3, 0);
    checkOutput(0, 0);

    $display("[TB] back-pressured drain with start held high");
    applyStimulus(4, 2, 0, 4, 1);
    checkOutput(1, 1);

    $display("[TB] empty jobs and row clamp");
    applyStimulus(5, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0);
    applyStimulus(20, 1, 0, 0, 0);
    checkOutput(0, 0);

    $display("[TB] reset in the middle of accumulation");
    cfg_rows   = AW'(8);
    cfg_passes = PW'(2);
    cfg_relu   = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data  = {COL{16'(7000 + k)}};
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_max_val", max_val, 0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_done", done, 0);
      @(posedge clk); #1;
    end
    applyStimulus(2, 1, 0, 4, 0);
    checkOutput(0, 0);

    $display("[TB] %0d/%0d checks passed", checkCnt - failCnt, checkCnt);
    $finish;
  end

endmodule
